// File: rtl/game_pkg.sv
// Shared game constants and state encodings.
// The VGA display controller imports this package too, so both sides decode game_state the same way.
package game_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_FINISH = 2'b10
    } game_state_t;

    typedef enum logic {
        PH_WARN = 1'b0,
        PH_BURN = 1'b1
    } phase_t;

    localparam int         LIFE_MAX_DEFAULT  = 5;
    localparam int         SCORE_MAX_DEFAULT = 3;
    localparam int         NUM_CELLS         = 9;
    localparam logic [8:0] SAFE_CENTER       = 9'h010;
    localparam logic [8:0] ALL_CELLS         = 9'h1FF;
    localparam logic [8:0] FULL_SAFE         = 9'h1EF;

endpackage

// File: rtl/game_engine_if.sv
// Game-engine bus.
// The player side drives start/box. The engine returns the registered game-state fields the renderer draws.
interface game_engine_if;

    logic       start;
    logic [8:0] box;
    logic [1:0] game_state;
    logic [8:0] fire_state;
    logic [8:0] gold_state;
    logic [8:0] next_fire_pattern;
    logic [8:0] hit_bitmap;
    logic [2:0] life;
    logic [3:0] score;
    logic       win;

    modport master (
        output start, box,
        input  game_state, fire_state, gold_state, next_fire_pattern,
        input  hit_bitmap, life, score, win
    );

    modport slave (
        input  start, box,
        output game_state, fire_state, gold_state, next_fire_pattern,
        output hit_bitmap, life, score, win
    );

endinterface

// File: rtl/game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting left.
module game_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign q      = lfsr_q;

    // Advance one step every cycle; the seed must be nonzero or the register locks up.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/game_engine.sv
// Game-logic stage feeding the VGA renderer. Contents:
//  - INIT/PLAY/FINISH state machine;
//  - WARN/BURN phase timer;
//  - fire-pattern and gold-placement generation;
//  - life, score and win bookkeeping.
// Every output is a register.
module game_engine
    import game_pkg::*;
#(
    parameter int          LIFE_MAX    = LIFE_MAX_DEFAULT,
    parameter int          SCORE_MAX   = SCORE_MAX_DEFAULT,
    parameter int          WARN_CYCLES = 50_000_000,
    parameter int          BURN_CYCLES = 50_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    game_engine_if.slave bus
);

    logic [15:0] lfsr;

    game_state_t state_q;
    phase_t      phase_q;
    logic [31:0] pcnt_q;
    logic [8:0]  fire_q;
    logic [8:0]  gold_q;
    logic [8:0]  next_q;
    logic [8:0]  hit_q;
    logic [2:0]  life_q;
    logic [3:0]  score_q;
    logic        win_q;

    logic [8:0]  pat_d;
    logic [8:0]  gold_start_d;
    logic [8:0]  gold_refill_d;
    logic [8:0]  strike_hit_d;
    logic [3:0]  score_inc_d;
    logic        collect_d;
    logic        win_d;
    logic        warn_end_d;
    logic        burn_end_d;
    logic        unused_lfsr_bits;

    // Never emit an all-safe or all-burning pattern.
    function automatic logic [8:0] sanitize(input logic [8:0] p);
        if (p == '0) return SAFE_CENTER;
        if (p == ALL_CELLS) return FULL_SAFE;
        return p;
    endfunction

    // Gold goes on the first non-burning cell found scanning from a random base cell (mod 9).
    function automatic logic [8:0] place(input logic [8:0] pat, input logic [3:0] sel);
        logic [3:0] base;
        logic [4:0] sum;
        logic [3:0] idx;
        logic       found;
        logic [8:0] onehot;
        base   = (sel >= 4'd9) ? sel - 4'd9 : sel;
        found  = 1'b0;
        onehot = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            sum = {1'b0, base} + 5'(k);
            if (sum >= 5'd9) sum = sum - 5'd9;
            idx = sum[3:0];
            if (!found && !pat[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return onehot;
    endfunction

    game_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // LFSR bits 11:9 feed neither the pattern nor the placement base.
    assign unused_lfsr_bits = ^lfsr[11:9];

    assign pat_d         = sanitize(lfsr[8:0]);
    assign gold_start_d  = place(pat_d, lfsr[15:12]);
    assign gold_refill_d = place(next_q, lfsr[15:12]);
    assign strike_hit_d  = bus.box & next_q;
    assign score_inc_d   = score_q + 4'd1;
    assign collect_d     = (|(bus.box & gold_q)) && (life_q != '0);
    assign win_d         = collect_d && (score_inc_d == 4'(SCORE_MAX));
    assign warn_end_d    = (phase_q == PH_WARN) && (pcnt_q == 32'(WARN_CYCLES - 1));
    assign burn_end_d    = (phase_q == PH_BURN) && (pcnt_q == 32'(BURN_CYCLES - 1));

    // Game FSM: every game-state output is updated here as a registered value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            phase_q <= PH_WARN;
            pcnt_q  <= '0;
            fire_q  <= '0;
            gold_q  <= '0;
            next_q  <= '0;
            hit_q   <= '0;
            life_q  <= 3'(LIFE_MAX);
            score_q <= '0;
            win_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (bus.start) begin
                        state_q <= ST_PLAY;
                        phase_q <= PH_WARN;
                        pcnt_q  <= '0;
                        life_q  <= 3'(LIFE_MAX);
                        score_q <= '0;
                        win_q   <= 1'b0;
                        next_q  <= pat_d;
                        gold_q  <= gold_start_d;
                    end
                end
                ST_PLAY: begin
                    if (win_d) begin
                        // The winning collection overrides any strike landing on the same edge.
                        state_q <= ST_FINISH;
                        win_q   <= 1'b1;
                        score_q <= score_inc_d;
                        gold_q  <= '0;
                        fire_q  <= '0;
                        hit_q   <= '0;
                        next_q  <= '0;
                    end else begin
                        if (collect_d) begin
                            score_q <= score_inc_d;
                            gold_q  <= '0;
                        end
                        if (warn_end_d) begin
                            fire_q  <= next_q;
                            next_q  <= pat_d;
                            hit_q   <= strike_hit_d;
                            if ((strike_hit_d != '0) && (life_q != '0)) begin
                                life_q <= life_q - 3'd1;
                            end
                            phase_q <= PH_BURN;
                            pcnt_q  <= '0;
                        end else if (burn_end_d) begin
                            fire_q <= '0;
                            hit_q  <= '0;
                            // collect_d needs a nonzero gold, so a refill never coincides with a collection.
                            if (gold_q == '0) begin
                                gold_q <= gold_refill_d;
                            end
                            if (life_q == '0) begin
                                state_q <= ST_FINISH;
                                win_q   <= 1'b0;
                            end else begin
                                phase_q <= PH_WARN;
                            end
                            pcnt_q <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + 32'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    if (bus.start) begin
                        state_q <= ST_INIT;
                        fire_q  <= '0;
                        gold_q  <= '0;
                        next_q  <= '0;
                        hit_q   <= '0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.game_state        = state_q;
    assign bus.fire_state        = fire_q;
    assign bus.gold_state        = gold_q;
    assign bus.next_fire_pattern = next_q;
    assign bus.hit_bitmap        = hit_q;
    assign bus.life              = life_q;
    assign bus.score             = score_q;
    assign bus.win               = win_q;

endmodule

// File: tb/tb_game_engine.sv
// Directed bench for game_engine with short WARN/BURN phases.
// A cycle model supplies the LFSR-dependent values.
module tb_game_engine;

    localparam int          WARN = 4;
    localparam int          BURN = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    game_engine_if bus ();

    game_engine #(
        .LIFE_MAX    (5),
        .SCORE_MAX   (3),
        .WARN_CYCLES (WARN),
        .BURN_CYCLES (BURN),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int         m_state, m_phase, m_pcnt;
    logic [8:0] m_fire, m_gold, m_next, m_hit;
    logic [2:0] m_life;
    logic [3:0] m_score;
    logic       m_win;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] m_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    function automatic logic [8:0] m_san(input logic [8:0] p);
        if (p == 9'h000) return 9'h010;
        else if (p == 9'h1FF) return 9'h1EF;
        else return p;
    endfunction

    function automatic logic [8:0] m_place(input logic [8:0] pat, input logic [3:0] sel);
        int base;
        base = int'(sel) % 9;
        for (int k = 0; k < 9; k++) begin
            int i;
            i = (base + k) % 9;
            if (pat[i] == 1'b0) return 9'(1 << i);
        end
        return 9'h000;
    endfunction

    function automatic logic [8:0] lowbit(input logic [8:0] v);
        return v & (~v + 9'd1);
    endfunction

    task automatic model_step();
        logic [8:0] o_gold, o_next;
        logic [2:0] o_life;
        logic [3:0] o_score;
        logic       col;
        if (!rst) begin
            m_state = 0; m_phase = 0; m_pcnt = 0;
            m_fire = 0; m_gold = 0; m_next = 0; m_hit = 0;
            m_life = 5; m_score = 0; m_win = 0; m_lfsr = SEED;
        end else begin
            o_gold = m_gold; o_next = m_next; o_life = m_life; o_score = m_score;
            if (m_state == 0) begin
                if (bus.start) begin
                    m_state = 1; m_phase = 0; m_pcnt = 0;
                    m_life = 5; m_score = 0; m_win = 0;
                    m_next = m_san(m_lfsr[8:0]);
                    m_gold = m_place(m_next, m_lfsr[15:12]);
                end
            end else if (m_state == 1) begin
                col = ((bus.box & o_gold) != 0) && (o_life != 0);
                if (col && (o_score + 1 == 3)) begin
                    m_state = 2; m_win = 1; m_score = o_score + 1;
                    m_gold = 0; m_fire = 0; m_hit = 0; m_next = 0;
                end else begin
                    if (col) begin m_score = o_score + 1; m_gold = 0; end
                    if (m_phase == 0 && m_pcnt == WARN - 1) begin
                        m_fire = o_next;
                        m_next = m_san(m_lfsr[8:0]);
                        m_hit  = bus.box & o_next;
                        if (m_hit != 0 && o_life != 0) m_life = o_life - 1;
                        m_phase = 1; m_pcnt = 0;
                    end else if (m_phase == 1 && m_pcnt == BURN - 1) begin
                        m_fire = 0; m_hit = 0;
                        if (o_gold == 0) m_gold = m_place(o_next, m_lfsr[15:12]);
                        if (o_life == 0) begin m_state = 2; m_win = 0; end
                        else m_phase = 0;
                        m_pcnt = 0;
                    end else begin
                        m_pcnt = m_pcnt + 1;
                    end
                end
            end else begin
                if (bus.start) begin
                    m_state = 0; m_fire = 0; m_gold = 0; m_next = 0; m_hit = 0;
                end
            end
            m_lfsr = m_step(m_lfsr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic goto_pre_strike(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_state == 1 && m_phase == 0 && m_pcnt == WARN - 1) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic goto_pre_burn_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_state == 1 && m_phase == 1 && m_pcnt == BURN - 1) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.start = 1'b0; bus.box = 9'h000;
        tick(); tick();
        vec_cnt++; if (bus.game_state !== 2'b00) begin err_cnt++; $display("FAIL rst_state: got %0d expected 0", bus.game_state); end
        vec_cnt++; if (bus.fire_state !== 9'h000) begin err_cnt++; $display("FAIL rst_fire: got %h expected 000", bus.fire_state); end
        vec_cnt++; if (bus.gold_state !== 9'h000) begin err_cnt++; $display("FAIL rst_gold: got %h expected 000", bus.gold_state); end
        vec_cnt++; if (bus.next_fire_pattern !== 9'h000) begin err_cnt++; $display("FAIL rst_next: got %h expected 000", bus.next_fire_pattern); end
        vec_cnt++; if (bus.hit_bitmap !== 9'h000) begin err_cnt++; $display("FAIL rst_hit: got %h expected 000", bus.hit_bitmap); end
        vec_cnt++; if (bus.life !== 3'd5) begin err_cnt++; $display("FAIL rst_life: got %0d expected 5", bus.life); end
        vec_cnt++; if (bus.score !== 4'd0) begin err_cnt++; $display("FAIL rst_score: got %0d expected 0", bus.score); end
        vec_cnt++; if (bus.win !== 1'b0) begin err_cnt++; $display("FAIL rst_win: got %b expected 0", bus.win); end
        vec_cnt++; if (dut.lfsr !== 16'hACE1) begin err_cnt++; $display("FAIL rst_lfsr: got %h expected ace1", dut.lfsr); end
        rst = 1'b1;
        tick();
        vec_cnt++; if (dut.lfsr !== 16'h59C3) begin err_cnt++; $display("FAIL lfsr_step1: got %h expected 59c3", dut.lfsr); end
        repeat (4) tick();
        vec_cnt++; if (dut.lfsr !== m_lfsr) begin err_cnt++; $display("FAIL lfsr_idle: got %h expected %h", dut.lfsr, m_lfsr); end
        vec_cnt++; if (bus.game_state !== 2'b00) begin err_cnt++; $display("FAIL idle_state: got %0d expected 0", bus.game_state); end
    endtask

    task automatic test_start_safe();
        logic [8:0] exp_pat, exp_gold, exp_new, safe;
        bit ok;
        exp_pat  = m_san(m_lfsr[8:0]);
        exp_gold = m_place(exp_pat, m_lfsr[15:12]);
        pulse_start();
        vec_cnt++; if (bus.game_state !== 2'b01) begin err_cnt++; $display("FAIL start_state: got %0d expected 1", bus.game_state); end
        vec_cnt++; if (bus.next_fire_pattern !== exp_pat) begin err_cnt++; $display("FAIL start_next: got %h expected %h", bus.next_fire_pattern, exp_pat); end
        vec_cnt++; if (bus.next_fire_pattern == 9'h000 || bus.next_fire_pattern == 9'h1FF) begin err_cnt++; $display("FAIL start_next_range: got %h expected not 000/1ff", bus.next_fire_pattern); end
        vec_cnt++; if (bus.gold_state !== exp_gold) begin err_cnt++; $display("FAIL start_gold: got %h expected %h", bus.gold_state, exp_gold); end
        vec_cnt++; if (!$onehot(bus.gold_state) || (bus.gold_state & bus.next_fire_pattern) != 9'h000) begin err_cnt++; $display("FAIL start_gold_disjoint: got %h expected onehot outside %h", bus.gold_state, bus.next_fire_pattern); end
        vec_cnt++; if (bus.life !== 3'd5 || bus.score !== 4'd0) begin err_cnt++; $display("FAIL start_life_score: got %0d/%0d expected 5/0", bus.life, bus.score); end
        safe = ~exp_pat & ~exp_gold;
        bus.box = lowbit(safe);
        goto_pre_strike(ok);
        if (!ok) begin vec_cnt++; err_cnt++; $display("FAIL safe_strike_reach: got timeout expected strike"); end
        exp_new = m_san(m_lfsr[8:0]);
        tick();
        vec_cnt++; if (bus.fire_state !== exp_pat) begin err_cnt++; $display("FAIL safe_fire: got %h expected %h", bus.fire_state, exp_pat); end
        vec_cnt++; if (bus.hit_bitmap !== 9'h000) begin err_cnt++; $display("FAIL safe_hit: got %h expected 000", bus.hit_bitmap); end
        vec_cnt++; if (bus.life !== 3'd5) begin err_cnt++; $display("FAIL safe_life: got %0d expected 5", bus.life); end
        vec_cnt++; if (bus.next_fire_pattern !== exp_new) begin err_cnt++; $display("FAIL safe_new_next: got %h expected %h", bus.next_fire_pattern, exp_new); end
        bus.box = 9'h000;
        goto_pre_burn_end(ok);
        if (!ok) begin vec_cnt++; err_cnt++; $display("FAIL safe_burn_reach: got timeout expected burn end"); end
        tick();
        vec_cnt++; if (bus.fire_state !== 9'h000 || bus.hit_bitmap !== 9'h000) begin err_cnt++; $display("FAIL burn_end_clear: got %h/%h expected 000/000", bus.fire_state, bus.hit_bitmap); end
        vec_cnt++; if (bus.gold_state !== exp_gold || bus.game_state !== 2'b01) begin err_cnt++; $display("FAIL burn_end_gold: got %h/%0d expected %h/1", bus.gold_state, bus.game_state, exp_gold); end
    endtask

    task automatic test_hit();
        logic [8:0] n0, cand, hb;
        bit ok;
        n0 = m_next;
        pulse_start();
        vec_cnt++; if (bus.game_state !== 2'b01 || bus.next_fire_pattern !== n0) begin err_cnt++; $display("FAIL start_ignored: got %0d/%h expected 1/%h", bus.game_state, bus.next_fire_pattern, n0); end
        goto_pre_strike(ok);
        if (!ok) begin vec_cnt++; err_cnt++; $display("FAIL hit_reach: got timeout expected strike"); end
        cand = m_next & ~m_gold;
        if (cand == 9'h000) cand = m_next;
        hb = lowbit(cand);
        bus.box = hb;
        tick();
        bus.box = 9'h000;
        vec_cnt++; if (bus.hit_bitmap !== hb) begin err_cnt++; $display("FAIL hit_bitmap: got %h expected %h", bus.hit_bitmap, hb); end
        vec_cnt++; if (bus.life !== 3'd4) begin err_cnt++; $display("FAIL hit_life: got %0d expected 4", bus.life); end
        repeat (BURN - 1) tick();
        vec_cnt++; if (bus.hit_bitmap !== hb) begin err_cnt++; $display("FAIL hit_hold: got %h expected %h", bus.hit_bitmap, hb); end
        tick();
        vec_cnt++; if (bus.hit_bitmap !== 9'h000) begin err_cnt++; $display("FAIL hit_clear: got %h expected 000", bus.hit_bitmap); end
        vec_cnt++; if (bus.life !== 3'd4) begin err_cnt++; $display("FAIL hit_once: got %0d expected 4", bus.life); end
    endtask

    task automatic test_win();
        int sc;
        sc = int'(m_score);
        for (int c = 0; c < 400 && sc < 3; c++) begin
            if (m_state == 1 && m_gold != 9'h000 && m_life != 3'd0) begin
                bus.box = m_gold;
                tick();
                bus.box = 9'h000;
                sc++;
                vec_cnt++; if (bus.score !== 4'(sc)) begin err_cnt++; $display("FAIL collect_score: got %0d expected %0d", bus.score, sc); end
                vec_cnt++; if (bus.gold_state !== 9'h000) begin err_cnt++; $display("FAIL collect_gold: got %h expected 000", bus.gold_state); end
            end else begin
                tick();
            end
        end
        if (sc != 3) begin vec_cnt++; err_cnt++; $display("FAIL win_reach: got %0d expected 3", sc); end
        vec_cnt++; if (bus.game_state !== 2'b10 || bus.win !== 1'b1) begin err_cnt++; $display("FAIL win_finish: got %0d/%b expected 2/1", bus.game_state, bus.win); end
        vec_cnt++; if (bus.fire_state !== 9'h000 || bus.hit_bitmap !== 9'h000 || bus.next_fire_pattern !== 9'h000) begin err_cnt++; $display("FAIL win_clear: got %h/%h/%h expected 000", bus.fire_state, bus.hit_bitmap, bus.next_fire_pattern); end
    endtask

    task automatic test_finish();
        logic [2:0] lf;
        lf = m_life;
        bus.box = 9'h1FF;
        repeat (3) tick();
        bus.box = 9'h000;
        vec_cnt++; if (bus.game_state !== 2'b10 || bus.score !== 4'd3 || bus.win !== 1'b1 || bus.life !== lf) begin err_cnt++; $display("FAIL finish_hold: got %0d/%0d/%b/%0d expected 2/3/1/%0d", bus.game_state, bus.score, bus.win, bus.life, lf); end
        pulse_start();
        vec_cnt++; if (bus.game_state !== 2'b00) begin err_cnt++; $display("FAIL finish_to_init: got %0d expected 0", bus.game_state); end
        vec_cnt++; if (bus.fire_state !== 9'h000 || bus.gold_state !== 9'h000 || bus.next_fire_pattern !== 9'h000 || bus.hit_bitmap !== 9'h000) begin err_cnt++; $display("FAIL init_clear: got %h/%h/%h/%h expected 000", bus.fire_state, bus.gold_state, bus.next_fire_pattern, bus.hit_bitmap); end
        vec_cnt++; if (bus.score !== 4'd3 || bus.win !== 1'b1) begin err_cnt++; $display("FAIL init_keep: got %0d/%b expected 3/1", bus.score, bus.win); end
    endtask

    task automatic test_loss();
        logic [8:0] cand, hb;
        logic [3:0] sc0;
        bit ok;
        pulse_start();
        vec_cnt++; if (bus.game_state !== 2'b01 || bus.life !== 3'd5 || bus.score !== 4'd0 || bus.win !== 1'b0) begin err_cnt++; $display("FAIL loss_start: got %0d/%0d/%0d/%b expected 1/5/0/0", bus.game_state, bus.life, bus.score, bus.win); end
        for (int n = 1; n <= 5; n++) begin
            goto_pre_strike(ok);
            if (!ok) begin vec_cnt++; err_cnt++; $display("FAIL loss_reach: got timeout expected strike %0d", n); end
            cand = m_next & ~m_gold;
            if (cand == 9'h000) cand = m_next;
            hb = lowbit(cand);
            bus.box = hb;
            tick();
            bus.box = 9'h000;
            vec_cnt++; if (bus.life !== 3'(5 - n) || bus.hit_bitmap !== hb) begin err_cnt++; $display("FAIL loss_hit: got %0d/%h expected %0d/%h", bus.life, bus.hit_bitmap, 5 - n, hb); end
        end
        if (m_gold != 9'h000) begin
            sc0 = m_score;
            bus.box = m_gold;
            tick();
            bus.box = 9'h000;
            vec_cnt++; if (bus.score !== sc0 || bus.gold_state === 9'h000) begin err_cnt++; $display("FAIL dead_collect: got %0d/%h expected %0d/nonzero", bus.score, bus.gold_state, sc0); end
        end
        goto_pre_burn_end(ok);
        if (!ok) begin vec_cnt++; err_cnt++; $display("FAIL loss_burn_reach: got timeout expected burn end"); end
        tick();
        vec_cnt++; if (bus.game_state !== 2'b10 || bus.win !== 1'b0 || bus.life !== 3'd0) begin err_cnt++; $display("FAIL loss_finish: got %0d/%b/%0d expected 2/0/0", bus.game_state, bus.win, bus.life); end
        pulse_start();
        vec_cnt++; if (bus.game_state !== 2'b00 || bus.life !== 3'd0) begin err_cnt++; $display("FAIL loss_init: got %0d/%0d expected 0/0", bus.game_state, bus.life); end
        pulse_start();
        vec_cnt++; if (bus.game_state !== 2'b01 || bus.life !== 3'd5 || bus.score !== 4'd0) begin err_cnt++; $display("FAIL restart: got %0d/%0d/%0d expected 1/5/0", bus.game_state, bus.life, bus.score); end
    endtask

    task automatic test_reset_mid();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        vec_cnt++; if (bus.game_state !== 2'b00 || bus.next_fire_pattern !== 9'h000 || bus.gold_state !== 9'h000) begin err_cnt++; $display("FAIL mid_reset: got %0d/%h/%h expected 0/000/000", bus.game_state, bus.next_fire_pattern, bus.gold_state); end
        vec_cnt++; if (bus.life !== 3'd5 || bus.score !== 4'd0 || dut.lfsr !== 16'hACE1) begin err_cnt++; $display("FAIL mid_reset_cnt: got %0d/%0d/%h expected 5/0/ace1", bus.life, bus.score, dut.lfsr); end
        rst = 1'b1;
    endtask

    task automatic test_sanitize();
        logic [8:0]  targets [2];
        logic [8:0]  results [2];
        logic [15:0] l;
        logic [8:0]  eg;
        int n;
        targets[0] = 9'h1FF; results[0] = 9'h1EF;
        targets[1] = 9'h000; results[1] = 9'h010;
        for (int t = 0; t < 2; t++) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            l = m_lfsr;
            n = 0;
            while (l[8:0] != targets[t] && n < 65535) begin
                l = m_step(l);
                n++;
            end
            if (n >= 65535) begin vec_cnt++; err_cnt++; $display("FAIL san_search: got none expected lfsr low %h", targets[t]); end
            repeat (n) tick();
            eg = m_place(results[t], l[15:12]);
            pulse_start();
            vec_cnt++; if (bus.next_fire_pattern !== results[t]) begin err_cnt++; $display("FAIL sanitize_%0d: got %h expected %h", t, bus.next_fire_pattern, results[t]); end
            vec_cnt++; if (bus.gold_state !== eg) begin err_cnt++; $display("FAIL san_gold_%0d: got %h expected %h", t, bus.gold_state, eg); end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.box = 9'h000;
        test_reset();
        test_start_safe();
        test_hit();
        test_win();
        test_finish();
        test_loss();
        test_reset_mid();
        test_sanitize();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/game_engine.md
# game_engine

Game-logic stage that sits directly upstream of the VGA display controller. It generates every game-state signal the renderer draws: the play state, the fire and gold cells, the mini-grid preview, the hit overlay, and life, score and win. It consumes the player's one-hot cell position and a start pulse. All outputs are registered, so the renderer sees values that are stable for the whole cycle.

## Interface
- `LIFE_MAX`, 5: lives at game start.
- `SCORE_MAX`, 3: golds needed to win.
- `WARN_CYCLES`, 50_000_000: cycles of WARN phase (preview shown, no fire).
- `BURN_CYCLES`, 50_000_000: cycles of BURN phase (fire active).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1: system clock.
- `rst`  in  1: reset. Synchronous, active-low: asserted when 0, sampled on the `clk` rising edge.
- `start`  in  1: one-cycle start/continue pulse (already debounced).
- `box`  in  9: one-hot player cell (row-major, bit 0 = top-left). 0 means no player.
- `game_state`  out  2: 00 INIT, 01 PLAY, 10 FINISH.
- `fire_state`  out  9: cells burning now.
- `gold_state`  out  9: gold cell (one-hot or 0).
- `next_fire_pattern`  out  9: upcoming burn pattern.
- `hit_bitmap`  out  9: `box & fire` latched at strike.
- `life`  out  3
- `score`  out  4
- `win`  out  1

## Operation
- Top FSM has three states.
  - INIT goes to PLAY on `start`.
  - PLAY goes to FINISH on a win or a loss.
  - FINISH goes to INIT on `start`.
  - `start` is ignored in PLAY.
- PLAY has two sub-phases, WARN and BURN, driven by a phase counter `pcnt`.
- 16-bit Fibonacci LFSR:
  - Taps 16, 14, 13, 11.
  - Steps every cycle in every state, so the moment of `start` randomizes play.
- `sanitize(p)` is applied to every new pattern:
  - If `p = lfsr[8:0]` is 0, use 9'h010.
  - If `p` is 9'h1FF, use 9'h1EF.
  - Otherwise use `p`.
  - This guarantees at least one burning cell and at least one safe cell.
- `place(pat)` selects the gold cell:
  - Start from base = `lfsr[15:12] mod 9`.
  - Scan i = (base+k) mod 9 for k = 0..8.
  - Return a one-hot of the first i with `pat[i]==0`.
- On the start edge in INIT:
  - `life` is set to `LIFE_MAX`; `score` and `win` are set to 0.
  - `next_fire_pattern` is set to `sanitize(lfsr)`; `gold_state` is set to `place` of that same value.
  - Phase is set to WARN with `pcnt` = 0.
- Strike: the edge ending WARN (`pcnt == WARN_CYCLES-1`).
  - `fire_state` takes the old `next_fire_pattern`.
  - `next_fire_pattern` takes the new `sanitize(lfsr)`.
  - `hit_bitmap` takes `box & old next_fire_pattern`.
  - If that AND is nonzero and `life` > 0, `life` decrements by 1.
  - Phase goes to BURN.
- Burn end: the edge ending BURN.
  - `fire_state` and `hit_bitmap` are cleared.
  - If `gold_state` is 0, it is set to `place(next_fire_pattern)`.
  - If `life` is 0, go to FINISH with `win` = 0. Otherwise go to WARN.
- Collection: checked every PLAY cycle.
  - Condition: `(box & gold_state) != 0` and `life != 0`.
  - Effect: `score` increments by 1 and `gold_state` is cleared.
  - If the new score equals `SCORE_MAX`, the next state is FINISH with `win` = 1 and `fire_state`, `hit_bitmap`, `next_fire_pattern` cleared.
  - A win takes precedence over a same-edge strike.
- In FINISH all outputs hold, except the cleared fields above. `life`, `score` and `win` remain visible.
- FINISH to INIT (on `start`): fire, gold, next and hit are cleared. `life`, `score` and `win` keep their values until the next start edge.

## Timing
- Reset values:
  - `game_state` = INIT.
  - `fire_state`, `gold_state`, `next_fire_pattern`, `hit_bitmap` = 0.
  - `life` = `LIFE_MAX`; `score` = 0; `win` = 0.
  - `lfsr` = `LFSR_SEED`; `pcnt` = 0; phase = WARN.
- Reset mid-PLAY returns to the reset values on the next edge.
- Latency is one cycle:
  - `start` sampled at edge N gives PLAY from edge N.
  - A `box` change gives the collection result one edge later.
- WARN lasts exactly `WARN_CYCLES` cycles and BURN exactly `BURN_CYCLES` cycles. `pcnt` resets to 0 at every phase change.
- `life` saturates at 0. `score` cannot exceed `SCORE_MAX`.
- `box` = 0 can never hit or collect.

## Structure
- Shared package `game_pkg` holds:
  - the state encodings INIT/PLAY/FINISH;
  - `LIFE_MAX` and `SCORE_MAX` defaults;
  - `SAFE_CENTER` = 9'h010.
  - The display controller uses the same state constants from this package.
- Sub-module `game_lfsr` provides the 16-bit LFSR (seed parameter, `clk`, `rst`, output `q`).
- `sanitize` and `place` are functions inside `game_engine`.

## Test plan
Run with `WARN_CYCLES=4` and `BURN_CYCLES=4`.
- Reset and idle: hold `rst`=0 for 2 cycles → outputs INIT/0/0/0/0/5/0/0. The LFSR advances with `start`=0 and the state stays INIT.
- Start and strike with the player safe:
  - Pulse `start` → PLAY; `next_fire_pattern` nonzero and not 9'h1FF; `gold_state` one-hot and disjoint from `next_fire_pattern`.
  - Place `box` on a safe cell → after 4 cycles `fire_state` equals the previous next, `hit_bitmap` = 0, `life` = 5.
- Hit: place `box` on a cell of the upcoming pattern → `hit_bitmap` = `box`; `life` 5→4 exactly once; `hit_bitmap` returns to 0 four cycles later.
- Win: collect gold 3 times → `score` 1, 2, 3; on the third collection the next edge gives FINISH, `win` = 1, `fire_state` = 0.
- Loss:
  - Force 5 hits → `life` reaches 0; FINISH at that BURN end with `win` = 0.
  - Standing on gold while `life` = 0 leaves `score` unchanged.
  - `start` → INIT; the next `start` gives `life` = 5, `score` = 0.
- Sanitize: force the LFSR to make `lfsr[8:0]` = 9'h1FF, then 9'h000 → patterns 9'h1EF and 9'h010 respectively.
